// File: rtl/npc_fetch_unit_pkg.sv
// Shared definitions for the next-PC fetch unit: npc_op encodings, default
// address vectors and the control-flow decode used by the target calc and top.
package npc_fetch_unit_pkg;

  typedef enum logic [2:0] {
    NPC_PC4    = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_J      = 3'b010,
    NPC_JR     = 3'b100,
    NPC_ERET   = 3'b101
  } npc_op_e;

  localparam logic [31:0] DEF_RESET_VEC   = 32'h0000_3000;
  localparam logic [31:0] DEF_HANDLER_VEC = 32'h0000_4180;
  localparam logic [31:0] DEF_TEXT_LO     = 32'h0000_3000;
  localparam logic [31:0] DEF_TEXT_HI     = 32'h0000_6ffc;

  typedef struct packed {
    logic taken;     // branch with a true condition
    logic jump;      // J or JR
    logic eret;      // exception return
    logic redirect;  // next fetch leaves the sequential path
    logic xfer_ds;   // opcode that owns a delay slot (taken or not)
  } npc_dec_t;

  // Unlisted opcodes decode to all-zero and therefore behave as PC+4.
  function automatic npc_dec_t decode_op(input logic [2:0] op, input logic branch);
    npc_dec_t d;
    d.taken    = (op == NPC_BRANCH) && branch;
    d.jump     = (op == NPC_J) || (op == NPC_JR);
    d.eret     = (op == NPC_ERET);
    d.redirect = d.taken || d.jump || d.eret;
    d.xfer_ds  = (op == NPC_BRANCH) || d.jump;
    return d;
  endfunction

endpackage

// File: rtl/npc_fetch_unit_target_calc.sv
// Purely combinational next-PC selection: interrupt vector first, then the
// decode-stage control-flow choice. All adds wrap modulo 2^ADDR_W.
module npc_target_calc
  import npc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] HANDLER_VEC = ADDR_W'(DEF_HANDLER_VEC)
) (
  input  logic              int_req,
  input  logic [2:0]        npc_op,
  input  logic              d_branch,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [15:0]       d_imm16,
  input  logic [25:0]       d_idx26,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] npc
);

  logic signed [17:0] br_off;
  logic [ADDR_W-1:0]  seq_pc;
  logic [ADDR_W-1:0]  br_pc;
  logic [ADDR_W-1:0]  j_pc;
  logic [27:0]        j_low;

  assign br_off = {d_imm16, 2'b00};
  assign seq_pc = f_pc + ADDR_W'(4);
  assign br_pc  = d_pc + ADDR_W'(4) + ADDR_W'(br_off);
  assign j_low  = {d_idx26, 2'b00};

  // J keeps the region bits of the D-stage PC above the 28-bit index window.
  if (ADDR_W > 28) begin : g_j_wide
    assign j_pc = {d_pc[ADDR_W-1:28], j_low};
  end else begin : g_j_narrow
    assign j_pc = j_low[ADDR_W-1:0];
  end

  always_comb begin
    npc = seq_pc;
    if (int_req) begin
      npc = HANDLER_VEC;
    end else begin
      case (npc_op)
        NPC_BRANCH: npc = d_branch ? br_pc : seq_pc;
        NPC_J:      npc = j_pc;
        NPC_JR:     npc = d_rs;
        NPC_ERET:   npc = epc;
        default:    npc = seq_pc;
      endcase
    end
  end

endmodule

// File: rtl/npc_fetch_unit.sv
// Fetch PC owner: registers the next PC, tracks delay-slot status and flags bad
// fetch addresses. Optional counters are built when NPC_PERF_CNT_EN is defined.
module npc_fetch_unit
  import npc_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] HANDLER_VEC = ADDR_W'(DEF_HANDLER_VEC),
  parameter logic [ADDR_W-1:0] TEXT_LO     = ADDR_W'(DEF_TEXT_LO),
  parameter logic [ADDR_W-1:0] TEXT_HI     = ADDR_W'(DEF_TEXT_HI),
  parameter bit                DELAY_SLOT  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              int_req,
  input  logic [2:0]        npc_op,
  input  logic              d_branch,
  input  logic [ADDR_W-1:0] d_pc,
  input  logic [15:0]       d_imm16,
  input  logic [25:0]       d_idx26,
  input  logic [ADDR_W-1:0] d_rs,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] f_pc,
  output logic              f_isdb,
  output logic              f_flush,
  output logic              d_cleardb,
  output logic              f_adel
`ifdef NPC_PERF_CNT_EN
  ,
  output logic [ADDR_W-1:0] cnt_taken,
  output logic [ADDR_W-1:0] cnt_jump,
  output logic [ADDR_W-1:0] cnt_int
`endif
);

  npc_dec_t          dec;
  logic [ADDR_W-1:0] npc;
  logic              upd;

  assign dec = decode_op(npc_op, d_branch);
  // An interrupt is not an update cycle: it overrides stall and drops the op.
  assign upd = !stall && !int_req;

  npc_target_calc #(
    .ADDR_W      (ADDR_W),
    .HANDLER_VEC (HANDLER_VEC)
  ) u_target (
    .int_req  (int_req),
    .npc_op   (npc_op),
    .d_branch (d_branch),
    .f_pc     (f_pc),
    .d_pc     (d_pc),
    .d_imm16  (d_imm16),
    .d_idx26  (d_idx26),
    .d_rs     (d_rs),
    .epc      (epc),
    .npc      (npc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      f_pc   <= RESET_VEC;
      f_isdb <= 1'b0;
    end else if (int_req || !stall) begin
      f_pc   <= npc;
      f_isdb <= DELAY_SLOT && !int_req && dec.xfer_ds;
    end
  end

  // Without a delay slot the already-fetched sequential instruction is wrong-path.
  assign f_flush   = !DELAY_SLOT && upd && dec.redirect;
  assign d_cleardb = !stall && dec.eret;
  assign f_adel    = (|f_pc[1:0]) || (f_pc < TEXT_LO) || (f_pc > TEXT_HI);

`ifdef NPC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_taken <= '0;
      cnt_jump  <= '0;
      cnt_int   <= '0;
    end else begin
      if (upd && dec.taken) cnt_taken <= cnt_taken + ADDR_W'(1);
      if (upd && dec.jump)  cnt_jump  <= cnt_jump + ADDR_W'(1);
      if (int_req)          cnt_int   <= cnt_int + ADDR_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_npc_fetch_unit.sv
// Bench for npc_fetch_unit: a delay-slot and a no-delay-slot instance share
// stimulus and are checked against an address-level reference model.
module tb_npc_fetch_unit;

  localparam int W = 32;
  localparam logic [W-1:0] RST_PC = 32'h0000_3000;
  localparam logic [W-1:0] HND_PC = 32'h0000_4180;

  logic         clk, reset, stall, int_req, d_branch;
  logic [2:0]   npc_op;
  logic [15:0]  d_imm16;
  logic [25:0]  d_idx26;
  logic [W-1:0] d_pc, d_rs, epc;

  logic [W-1:0] f_pc_ds, f_pc_nd;
  logic         isdb_ds, isdb_nd, flush_ds, flush_nd, clr_ds, clr_nd, adel_ds, adel_nd;
`ifdef NPC_PERF_CNT_EN
  logic [W-1:0] ct_ds, cj_ds, ci_ds, ct_nd, cj_nd, ci_nd;
`endif

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state
  logic [W-1:0] m_pc;
  logic         m_isdb;
  logic [W-1:0] m_ct, m_cj, m_ci;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  npc_fetch_unit #(.DELAY_SLOT(1'b1)) dut_ds (
    .clk(clk), .reset(reset), .stall(stall), .int_req(int_req), .npc_op(npc_op),
    .d_branch(d_branch), .d_pc(d_pc), .d_imm16(d_imm16), .d_idx26(d_idx26),
    .d_rs(d_rs), .epc(epc), .f_pc(f_pc_ds), .f_isdb(isdb_ds), .f_flush(flush_ds),
    .d_cleardb(clr_ds), .f_adel(adel_ds)
`ifdef NPC_PERF_CNT_EN
    , .cnt_taken(ct_ds), .cnt_jump(cj_ds), .cnt_int(ci_ds)
`endif
  );

  npc_fetch_unit #(.DELAY_SLOT(1'b0)) dut_nd (
    .clk(clk), .reset(reset), .stall(stall), .int_req(int_req), .npc_op(npc_op),
    .d_branch(d_branch), .d_pc(d_pc), .d_imm16(d_imm16), .d_idx26(d_idx26),
    .d_rs(d_rs), .epc(epc), .f_pc(f_pc_nd), .f_isdb(isdb_nd), .f_flush(flush_nd),
    .d_cleardb(clr_nd), .f_adel(adel_nd)
`ifdef NPC_PERF_CNT_EN
    , .cnt_taken(ct_nd), .cnt_jump(cj_nd), .cnt_int(ci_nd)
`endif
  );

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_adel(input logic [W-1:0] pc);
    return (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h6ffc);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic [2:0] op, input logic br, input logic [W-1:0] dpc,
                       input logic [15:0] imm, input logic [25:0] idx, input logic [W-1:0] rs,
                       input logic [W-1:0] ep, input logic st, input logic ir, input logic rst);
    npc_op = op; d_branch = br; d_pc = dpc; d_imm16 = imm; d_idx26 = idx;
    d_rs = rs; epc = ep; stall = st; int_req = ir; reset = rst;
  endtask

  // Checks the comb outputs for the current inputs, advances one edge, checks state.
  task automatic step(input string tag);
    logic         redirect, nisdb;
    logic [W-1:0] npc, exp_pc;
    int           off;
    #1;
    redirect = (npc_op == 3'b010) || (npc_op == 3'b100) || (npc_op == 3'b101) ||
               (npc_op == 3'b001 && d_branch);
    check({tag, "/flush_nd"}, flush_nd, !stall && !int_req && redirect);
    check({tag, "/flush_ds"}, flush_ds, 1'b0);
    check({tag, "/cleardb_ds"}, clr_ds, !stall && npc_op == 3'b101);
    check({tag, "/cleardb_nd"}, clr_nd, !stall && npc_op == 3'b101);
    check({tag, "/adel"}, adel_ds, ref_adel(m_pc));
    check({tag, "/adel_nd"}, adel_nd, ref_adel(m_pc));
    npc = m_pc;
    nisdb = m_isdb;
    if (reset) begin
      npc = RST_PC; nisdb = 1'b0; m_ct = '0; m_cj = '0; m_ci = '0;
    end else if (int_req) begin
      npc = HND_PC; nisdb = 1'b0; m_ci = m_ci + 1;
    end else if (!stall) begin
      nisdb = 1'b0;
      case (npc_op)
        3'b001: begin
          nisdb = 1'b1;
          if (d_branch) begin
            off = int'($signed(d_imm16)) * 4;
            npc = d_pc + 4 + W'(off);
            m_ct = m_ct + 1;
          end else begin
            npc = m_pc + 4;
          end
        end
        3'b010: begin
          npc = (d_pc & 32'hF000_0000) | (W'(d_idx26) << 2);
          nisdb = 1'b1; m_cj = m_cj + 1;
        end
        3'b100: begin npc = d_rs; nisdb = 1'b1; m_cj = m_cj + 1; end
        3'b101: npc = epc;
        default: npc = m_pc + 4;
      endcase
    end
    exp_q.push_back(npc);
    @(posedge clk);
    #1;
    exp_pc = exp_q.pop_front();
    m_pc = npc;
    m_isdb = nisdb;
    check({tag, "/f_pc_ds"}, f_pc_ds, exp_pc);
    check({tag, "/f_pc_nd"}, f_pc_nd, exp_pc);
    check({tag, "/isdb_ds"}, isdb_ds, m_isdb);
    check({tag, "/isdb_nd"}, isdb_nd, 1'b0);
`ifdef NPC_PERF_CNT_EN
    check({tag, "/cnt_taken"}, ct_ds, m_ct);
    check({tag, "/cnt_jump"}, cj_ds, m_cj);
    check({tag, "/cnt_int"}, ci_ds, m_ci);
    check({tag, "/cnt_taken_nd"}, ct_nd, m_ct);
`endif
  endtask

  function automatic logic [W-1:0] rand_text_addr();
    return 32'h3000 + W'($urandom_range(0, 32'hFFF) << 2);
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    drive(3'b000, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    m_pc = RST_PC; m_isdb = 1'b0; m_ct = '0; m_cj = '0; m_ci = '0;
    check("reset/f_pc", f_pc_ds, 32'h3000);
    check("reset/isdb", isdb_ds, 1'b0);
    check("reset/adel", adel_ds, 1'b0);
    check("reset/f_pc_nd", f_pc_nd, 32'h3000);

    // Sequential fetch out of reset
    drive(3'b000, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    step("pc4_a");
    check("pc4_a/lit", f_pc_ds, 32'h3004);
    step("pc4_b");
    check("pc4_b/lit", f_pc_ds, 32'h3008);

    // Taken backward branch
    drive(3'b001, 1'b1, 32'h3010, 16'hFFFC, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    check("br_taken/flush_lit", flush_nd, 1'b1);
    step("br_taken");
    check("br_taken/pc_lit", f_pc_ds, 32'h3004);
    check("br_taken/isdb_lit", isdb_ds, 1'b1);
    check("br_taken/isdb_nd_lit", isdb_nd, 1'b0);

    // Misaligned and out-of-range jump-register targets
    drive(3'b100, 1'b0, 32'h3004, '0, '0, 32'h3001, '0, 1'b0, 1'b0, 1'b0);
    step("jr_misal");
    check("jr_misal/adel_lit", adel_ds, 1'b1);
    drive(3'b100, 1'b0, 32'h3004, '0, '0, 32'h7000, '0, 1'b0, 1'b0, 1'b0);
    step("jr_high");
    check("jr_high/adel_lit", adel_ds, 1'b1);
    drive(3'b100, 1'b0, 32'h3004, '0, '0, 32'h3020, '0, 1'b0, 1'b0, 1'b0);
    step("jr_back");
    check("jr_back/adel_lit", adel_ds, 1'b0);

    // J held under stall for three cycles, then released
    drive(3'b010, 1'b0, 32'h3010, '0, 26'h0000C10, '0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("j_stall");
    check("j_stall/pc_hold", f_pc_ds, 32'h3020);
    check("j_stall/isdb_hold", isdb_ds, 1'b1);
    stall = 1'b0;
    step("j_go");
    check("j_go/pc_lit", f_pc_ds, 32'h3040);

    // Interrupt beats stall and ERET; then a lone ERET
    drive(3'b101, 1'b0, 32'h3040, '0, '0, '0, 32'h3040, 1'b1, 1'b1, 1'b0);
    #1;
    check("int/cleardb_lit", clr_ds, 1'b0);
    step("int");
    check("int/pc_lit", f_pc_ds, 32'h4180);
    check("int/isdb_lit", isdb_ds, 1'b0);
    drive(3'b101, 1'b0, 32'h4180, '0, '0, '0, 32'h3040, 1'b0, 1'b0, 1'b0);
    #1;
    check("eret/cleardb_lit", clr_ds, 1'b1);
    step("eret");
    check("eret/pc_lit", f_pc_ds, 32'h3040);
    check("eret/isdb_lit", isdb_ds, 1'b0);

    // Reset wins over stall and interrupt
    drive(3'b010, 1'b0, 32'h3040, '0, 26'h123, '0, '0, 1'b1, 1'b1, 1'b1);
    step("rst_win");
    check("rst_win/pc_lit", f_pc_ds, 32'h3000);

    // Counter scenario: 5 taken, 2 not-taken, 3 jumps with one stalled first
    for (int i = 0; i < 5; i++) begin
      drive(3'b001, 1'b1, 32'h3010, 16'h0001, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      step("cnt_taken");
    end
    for (int i = 0; i < 2; i++) begin
      drive(3'b001, 1'b0, 32'h3010, 16'h0001, '0, '0, '0, 1'b0, 1'b0, 1'b0);
      step("cnt_nt");
    end
    drive(3'b010, 1'b0, 32'h3010, '0, 26'h0000C20, '0, '0, 1'b0, 1'b0, 1'b0);
    step("cnt_j");
    drive(3'b100, 1'b0, 32'h3080, '0, '0, 32'h3100, '0, 1'b0, 1'b0, 1'b0);
    step("cnt_jr");
    drive(3'b010, 1'b0, 32'h3100, '0, 26'h0000C40, '0, '0, 1'b1, 1'b0, 1'b0);
    step("cnt_j_stall");
    stall = 1'b0;
    step("cnt_j_go");
`ifdef NPC_PERF_CNT_EN
    check("cnt/taken_lit", ct_ds, 32'd5);
    check("cnt/jump_lit", cj_ds, 32'd3);
    check("cnt/int_lit", ci_ds, 32'd0);
`endif
    drive(3'b000, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    step("cnt_reset");
`ifdef NPC_PERF_CNT_EN
    check("cnt_reset/taken_lit", ct_ds, 32'd0);
    check("cnt_reset/jump_lit", cj_ds, 32'd0);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      npc_op   = 3'($urandom_range(0, 7));
      d_branch = 1'($urandom_range(0, 1));
      d_pc     = rand_text_addr();
      d_imm16  = 16'($urandom);
      d_idx26  = 26'($urandom);
      d_rs     = ($urandom_range(0, 3) == 0) ? W'($urandom) : rand_text_addr();
      epc      = ($urandom_range(0, 7) == 0) ? W'($urandom) : rand_text_addr();
      stall    = ($urandom_range(0, 3) == 0);
      int_req  = ($urandom_range(0, 15) == 0);
      reset    = ($urandom_range(0, 63) == 0);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
